// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control path: FSM states, op codes,
// datapath select codes and the bundled control-output payload.
package cpu_ctrl_pkg;

   localparam int unsigned STATE_W = 4;
   localparam int unsigned WAIT_W  = 8;

   localparam logic [STATE_W-1:0] ENC_FETCH  = 4'd0;
   localparam logic [STATE_W-1:0] ENC_DECODE = 4'd1;
   localparam logic [STATE_W-1:0] ENC_MEMADR = 4'd2;
   localparam logic [STATE_W-1:0] ENC_MEMRD  = 4'd3;
   localparam logic [STATE_W-1:0] ENC_MEMWB  = 4'd4;
   localparam logic [STATE_W-1:0] ENC_MEMWR  = 4'd5;
   localparam logic [STATE_W-1:0] ENC_EXECR  = 4'd6;
   localparam logic [STATE_W-1:0] ENC_EXECI  = 4'd7;
   localparam logic [STATE_W-1:0] ENC_ALUWB  = 4'd8;
   localparam logic [STATE_W-1:0] ENC_BRANCH = 4'd9;
   localparam logic [STATE_W-1:0] ENC_FAULT  = 4'd10;

   typedef enum logic [STATE_W-1:0] {
      ST_FETCH  = ENC_FETCH,
      ST_DECODE = ENC_DECODE,
      ST_MEMADR = ENC_MEMADR,
      ST_MEMRD  = ENC_MEMRD,
      ST_MEMWB  = ENC_MEMWB,
      ST_MEMWR  = ENC_MEMWR,
      ST_EXECR  = ENC_EXECR,
      ST_EXECI  = ENC_EXECI,
      ST_ALUWB  = ENC_ALUWB,
      ST_BRANCH = ENC_BRANCH,
      ST_FAULT  = ENC_FAULT
   } state_t;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   localparam logic [1:0] SRCA_RN     = 2'b00;
   localparam logic [1:0] SRCA_PC     = 2'b01;
   localparam logic [1:0] SRCA_ALUOUT = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [3:0] REG_PC = 4'd15;

   typedef struct packed {
      logic       ir_write;
      logic       adr_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic       alu_op;
      logic       reg_write;
      logic       mem_write;
      logic       pc_write;
   } ctrl_out_t;

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational map from FSM state plus the rd/cond_ex/mem_ready qualifiers
// to every datapath enable and mux select.
module ctrl_out_decode
   import cpu_ctrl_pkg::*;
(
   input  state_t     i_state,
   input  logic [3:0] i_rd,
   input  logic       i_cond_ex,
   input  logic       i_mem_ready,
   output ctrl_out_t  o_ctrl
);

   logic w_rd_pc;
   assign w_rd_pc = (i_rd == REG_PC);

   always_comb begin
      o_ctrl = '0;
      case (i_state)
         ST_FETCH: begin
            o_ctrl.alu_src_a  = SRCA_PC;
            o_ctrl.alu_src_b  = SRCB_FOUR;
            o_ctrl.result_src = RES_ALU;
            o_ctrl.ir_write   = i_mem_ready;
            o_ctrl.pc_write   = i_mem_ready;
         end
         // PC+8 is precomputed here so R15 reads see the architectural value
         ST_DECODE: begin
            o_ctrl.alu_src_a  = SRCA_PC;
            o_ctrl.alu_src_b  = SRCB_FOUR;
            o_ctrl.result_src = RES_ALU;
         end
         ST_EXECR: begin
            o_ctrl.alu_src_a = SRCA_RN;
            o_ctrl.alu_src_b = SRCB_RD2;
            o_ctrl.alu_op    = 1'b1;
         end
         ST_EXECI: begin
            o_ctrl.alu_src_a = SRCA_RN;
            o_ctrl.alu_src_b = SRCB_IMM;
            o_ctrl.alu_op    = 1'b1;
         end
         ST_ALUWB: begin
            o_ctrl.result_src = RES_ALUOUT;
            o_ctrl.reg_write  = i_cond_ex & ~w_rd_pc;
            o_ctrl.pc_write   = i_cond_ex & w_rd_pc;
         end
         ST_MEMADR: begin
            o_ctrl.alu_src_a = SRCA_RN;
            o_ctrl.alu_src_b = SRCB_IMM;
         end
         ST_MEMRD: begin
            o_ctrl.adr_src = 1'b1;
         end
         ST_MEMWR: begin
            o_ctrl.adr_src   = 1'b1;
            o_ctrl.mem_write = i_cond_ex;
         end
         ST_MEMWB: begin
            o_ctrl.result_src = RES_DATA;
            o_ctrl.reg_write  = i_cond_ex & ~w_rd_pc;
            o_ctrl.pc_write   = i_cond_ex & w_rd_pc;
         end
         ST_BRANCH: begin
            o_ctrl.alu_src_a  = SRCA_ALUOUT;
            o_ctrl.alu_src_b  = SRCB_IMM;
            o_ctrl.result_src = RES_ALU;
            o_ctrl.pc_write   = i_cond_ex;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main sequencer for the multicycle ARM datapath: state register, next-state
// logic, bounded memory-wait counter and sticky fault flag.
module multicycle_ctrl_fsm
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] op,
   input  logic [5:0] funct,
   input  logic [3:0] rd,
   input  logic       cond_ex,
   input  logic       mem_ready,
   output logic       ir_write,
   output logic       adr_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic       alu_op,
   output logic       reg_write,
   output logic       mem_write,
   output logic       pc_write,
   output logic       fault
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [WAIT_W-1:0]   r_wait_cnt;
   logic [WAIT_W-1:0]   w_wait_nxt;
   logic                r_fault;
   logic                w_fault_set;
   logic                w_waiting;
   logic                w_wait_hit;
   ctrl_out_t           w_dec;
   ctrl_out_t           w_out;
   logic                w_unused_funct;

   assign w_unused_funct = ^funct[4:1];
   assign w_wait_hit     = (r_wait_cnt == WAIT_W'(WAIT_MAX));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_FETCH;
         r_wait_cnt <= '0;
         r_fault    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
         if (w_fault_set) r_fault <= 1'b1;
      end
   end

   // Counter only advances while stalled in a memory state; every other path clears it
   always_comb begin
      w_state_nxt = r_state;
      w_fault_set = 1'b0;
      w_waiting   = 1'b0;
      case (r_state)
         ST_FETCH: begin
            if (mem_ready)       w_state_nxt = ST_DECODE;
            else if (w_wait_hit) begin
               w_state_nxt = ST_FAULT;
               w_fault_set = 1'b1;
            end else             w_waiting = 1'b1;
         end
         ST_DECODE: begin
            case (op)
               OP_DP:   w_state_nxt = funct[5] ? ST_EXECI : ST_EXECR;
               OP_MEM:  w_state_nxt = ST_MEMADR;
               OP_BR:   w_state_nxt = ST_BRANCH;
               default: w_state_nxt = ST_FETCH;
            endcase
         end
         ST_EXECR, ST_EXECI: w_state_nxt = ST_ALUWB;
         ST_MEMADR: w_state_nxt = funct[0] ? ST_MEMRD : ST_MEMWR;
         ST_MEMRD: begin
            if (mem_ready)       w_state_nxt = ST_MEMWB;
            else if (w_wait_hit) begin
               w_state_nxt = ST_FAULT;
               w_fault_set = 1'b1;
            end else             w_waiting = 1'b1;
         end
         ST_MEMWR: begin
            if (!cond_ex || mem_ready) w_state_nxt = ST_FETCH;
            else if (w_wait_hit) begin
               w_state_nxt = ST_FAULT;
               w_fault_set = 1'b1;
            end else                   w_waiting = 1'b1;
         end
         ST_ALUWB, ST_MEMWB, ST_BRANCH: w_state_nxt = ST_FETCH;
         ST_FAULT: w_state_nxt = ST_FAULT;
         default:  w_state_nxt = ST_FETCH;
      endcase
      w_wait_nxt = w_waiting ? (r_wait_cnt + WAIT_W'(1)) : '0;
   end

   ctrl_out_decode u_out_dec (
      .i_state     (r_state),
      .i_rd        (rd),
      .i_cond_ex   (cond_ex),
      .i_mem_ready (mem_ready),
      .o_ctrl      (w_dec)
   );

   assign w_out = reset ? '0 : w_dec;

   assign ir_write   = w_out.ir_write;
   assign adr_src    = w_out.adr_src;
   assign alu_src_a  = w_out.alu_src_a;
   assign alu_src_b  = w_out.alu_src_b;
   assign result_src = w_out.result_src;
   assign alu_op     = w_out.alu_op;
   assign reg_write  = w_out.reg_write;
   assign mem_write  = w_out.mem_write;
   assign pc_write   = w_out.pc_write;
   assign fault      = r_fault & ~reset;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: per-cycle output vectors checked
// against hand-computed patterns for each instruction class, timeout and reset.
module tb_multicycle_ctrl_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic       cond_ex;
   logic       mem_ready;
   logic       ir_write, adr_src, alu_op, reg_write, mem_write, pc_write, fault;
   logic [1:0] alu_src_a, alu_src_b, result_src;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   multicycle_ctrl_fsm #(.WAIT_MAX(15)) dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .rd         (rd),
      .cond_ex    (cond_ex),
      .mem_ready  (mem_ready),
      .ir_write   (ir_write),
      .adr_src    (adr_src),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .result_src (result_src),
      .alu_op     (alu_op),
      .reg_write  (reg_write),
      .mem_write  (mem_write),
      .pc_write   (pc_write),
      .fault      (fault)
   );

   // {ir_write, adr_src, alu_src_a, alu_src_b, result_src, alu_op, reg_write, mem_write, pc_write, fault}
   logic [13:0] w_obs;
   assign w_obs = {ir_write, adr_src, alu_src_a, alu_src_b, result_src,
                   alu_op, reg_write, mem_write, pc_write, fault};

   localparam logic [13:0] V_ZERO       = 14'b0_0_00_00_00_0_0_0_0_0;
   localparam logic [13:0] V_FETCH_RDY  = 14'b1_0_01_10_10_0_0_0_1_0;
   localparam logic [13:0] V_FETCH_WAIT = 14'b0_0_01_10_10_0_0_0_0_0;
   localparam logic [13:0] V_DEC        = 14'b0_0_01_10_10_0_0_0_0_0;
   localparam logic [13:0] V_EXECR      = 14'b0_0_00_00_00_1_0_0_0_0;
   localparam logic [13:0] V_EXECI      = 14'b0_0_00_01_00_1_0_0_0_0;
   localparam logic [13:0] V_ALUWB_RW   = 14'b0_0_00_00_00_0_1_0_0_0;
   localparam logic [13:0] V_ALUWB_PC   = 14'b0_0_00_00_00_0_0_0_1_0;
   localparam logic [13:0] V_MEMADR     = 14'b0_0_00_01_00_0_0_0_0_0;
   localparam logic [13:0] V_MEMRD      = 14'b0_1_00_00_00_0_0_0_0_0;
   localparam logic [13:0] V_MEMWB_PC   = 14'b0_0_00_00_01_0_0_0_1_0;
   localparam logic [13:0] V_MEMWB_RW   = 14'b0_0_00_00_01_0_1_0_0_0;
   localparam logic [13:0] V_MEMWR_ST   = 14'b0_1_00_00_00_0_0_1_0_0;
   localparam logic [13:0] V_MEMWR_NO   = 14'b0_1_00_00_00_0_0_0_0_0;
   localparam logic [13:0] V_BR_PC      = 14'b0_0_10_01_10_0_0_0_1_0;
   localparam logic [13:0] V_BR_NC      = 14'b0_0_10_01_10_0_0_0_0_0;
   localparam logic [13:0] V_FAULT      = 14'b0_0_00_00_00_0_0_0_0_1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%b exp=%b", tag, got[13:0], exp[13:0]);
      end
   endtask

   // Inputs are set at the falling edge; sample 1 time unit later, then move to the next falling edge
   task automatic cyc(input string tag, input logic [13:0] exp);
      #1;
      chk(tag, 32'(w_obs), 32'(exp));
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; op = 2'b00; funct = 6'b0; rd = 4'd0; cond_ex = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      cyc("rst", V_ZERO);
      reset = 1'b0;

      // ADD r1 register form
      op = 2'b00; funct = 6'b000000; rd = 4'd1; cond_ex = 1'b1; mem_ready = 1'b1;
      cyc("add_fetch", V_FETCH_RDY); cyc("add_dec", V_DEC);
      cyc("add_exr", V_EXECR);       cyc("add_wb", V_ALUWB_RW);

      // Immediate form
      funct = 6'b100000; rd = 4'd2;
      cyc("addi_fetch", V_FETCH_RDY); cyc("addi_dec", V_DEC);
      cyc("addi_exi", V_EXECI);       cyc("addi_wb", V_ALUWB_RW);

      // DP to R15, condition failed then passed
      funct = 6'b000000; rd = 4'd15; cond_ex = 1'b0;
      cyc("r15nc_fetch", V_FETCH_RDY); cyc("r15nc_dec", V_DEC);
      cyc("r15nc_exr", V_EXECR);       cyc("r15nc_wb", V_ZERO);
      cond_ex = 1'b1;
      cyc("r15_fetch", V_FETCH_RDY); cyc("r15_dec", V_DEC);
      cyc("r15_exr", V_EXECR);       cyc("r15_wb", V_ALUWB_PC);

      // LDR R15 with one stall cycle in MEMRD
      op = 2'b01; funct = 6'b000001; rd = 4'd15;
      cyc("ldr15_fetch", V_FETCH_RDY); cyc("ldr15_dec", V_DEC); cyc("ldr15_adr", V_MEMADR);
      mem_ready = 1'b0; cyc("ldr15_wait", V_MEMRD);
      mem_ready = 1'b1; cyc("ldr15_rd", V_MEMRD);
      cyc("ldr15_wb", V_MEMWB_PC);

      // LDR r4
      rd = 4'd4;
      cyc("ldr_fetch", V_FETCH_RDY); cyc("ldr_dec", V_DEC); cyc("ldr_adr", V_MEMADR);
      cyc("ldr_rd", V_MEMRD);        cyc("ldr_wb", V_MEMWB_RW);

      // STR with condition failed: no strobe, straight back to FETCH
      funct = 6'b000000; rd = 4'd3; cond_ex = 1'b0;
      cyc("strnc_fetch", V_FETCH_RDY); cyc("strnc_dec", V_DEC); cyc("strnc_adr", V_MEMADR);
      cyc("strnc_wr", V_MEMWR_NO);     cyc("strnc_back", V_FETCH_RDY);

      // Branch not taken (DECODE continues from the fetch above), then taken
      op = 2'b10;
      cyc("bnc_dec", V_DEC); cyc("bnc_br", V_BR_NC);
      cond_ex = 1'b1;
      cyc("b_fetch", V_FETCH_RDY); cyc("b_dec", V_DEC); cyc("b_br", V_BR_PC);

      // STR with condition passed
      op = 2'b01; funct = 6'b000000;
      cyc("str_fetch", V_FETCH_RDY); cyc("str_dec", V_DEC); cyc("str_adr", V_MEMADR);
      cyc("str_wr", V_MEMWR_ST);

      // Undefined op goes from DECODE back to FETCH
      op = 2'b11;
      cyc("und_fetch", V_FETCH_RDY); cyc("und_dec", V_DEC);
      cyc("und_back", V_FETCH_RDY);  cyc("und_dec2", V_DEC);

      // Exactly WAIT_MAX stalled cycles in FETCH: ready on the next cycle wins
      mem_ready = 1'b0;
      for (int i = 0; i < 15; i++) cyc("to_wait", V_FETCH_WAIT);
      mem_ready = 1'b1;
      cyc("to_edge_ok", V_FETCH_RDY);
      cyc("to_dec", V_DEC);

      // One more stalled cycle times out into FAULT, which holds until reset
      mem_ready = 1'b0;
      for (int i = 0; i < 16; i++) cyc("to_wait2", V_FETCH_WAIT);
      cyc("fault", V_FAULT);
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) cyc("fault_hold", V_FAULT);
      reset = 1'b1;
      cyc("fault_rst", V_ZERO);
      reset = 1'b0;

      // Reset in the middle of a stalled store strobe
      op = 2'b01; funct = 6'b000000; rd = 4'd3; cond_ex = 1'b1;
      cyc("rw_fetch0", V_FETCH_RDY); cyc("rw_dec", V_DEC); cyc("rw_adr", V_MEMADR);
      mem_ready = 1'b0;
      cyc("rw_st", V_MEMWR_ST); cyc("rw_st2", V_MEMWR_ST);
      reset = 1'b1;
      cyc("rw_rst", V_ZERO);
      reset = 1'b0; mem_ready = 1'b1;
      cyc("rw_fetch", V_FETCH_RDY);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
